// File: rtl/rom_arb_pkg.sv
// Shared types for the instruction-ROM fetch arbiter: FSM states and
// requester (owner) encodings.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on contention the port that
// did not win last time is chosen.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    // NOTE: every output gets a default first so no path through the block
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        winner = PORT0;
        gnt    = 2'b00;
        case (req)
            2'b01:   winner = PORT0;
            2'b10:   winner = PORT1;
            2'b11:   winner = ~last;
            default: winner = PORT0;
        endcase
        if (req != 2'b00) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares the single instruction-ROM port between the fetch unit (port 0)
// and the debug/loader path (port 1), with a watchdog on unanswered reads.
module rom_fetch_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_rvalid_o,
    output logic              m0_rerr_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_gnt_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_rvalid_o,
    output logic              m1_rerr_o,
    output logic              rom_request_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              rom_dataOk_i
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e            state, state_next;
    logic              owner, last_owner;
    logic [WD_W-1:0]   watchdog;
    logic [1:0]        arb_req, arb_gnt;
    logic              winner;
    logic              grant, resp_ok, resp_to, resp;

    assign arb_req = {m1_req_i, m0_req_i};

    rr_arb2 u_rr_arb2 (
        .req    (arb_req),
        .last   (last_owner),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    assign grant   = (state == IDLE) && (arb_req != 2'b00);
    assign resp_ok = (state == WAIT) && rom_dataOk_i;
    assign resp_to = (state == WAIT) && !rom_dataOk_i && (watchdog == WD_W'(TIMEOUT - 1));
    assign resp    = resp_ok || resp_to;

    // Grants are masked while reset is held so no requester sees a stray pulse.
    assign m0_gnt_o = grant && reset_n && arb_gnt[0];
    assign m1_gnt_o = grant && reset_n && arb_gnt[1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rerr_o   = 1'b0;
        m1_rerr_o   = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Timed-out accesses return zero data alongside the error flag.
        if (owner == PORT0) begin
            m0_rvalid_o = resp;
            m0_rerr_o   = resp_to;
            m0_rdata_o  = resp_ok ? rom_data_i : '0;
        end else begin
            m1_rvalid_o = resp;
            m1_rerr_o   = resp_to;
            m1_rdata_o  = resp_ok ? rom_data_i : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_request_o <= 1'b0;
            rom_addr_o    <= '0;
            owner         <= PORT0;
            last_owner    <= PORT1;
            watchdog      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner         <= winner;
                        last_owner    <= winner;
                        rom_addr_o    <= (winner == PORT1) ? m1_addr_i : m0_addr_i;
                        rom_request_o <= 1'b1;
                        watchdog      <= '0;
                    end
                end
                ISSUE: rom_request_o <= 1'b0;
                WAIT:  if (!resp) watchdog <= watchdog + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a one-cycle-latency ROM model.
module tb_rom_fetch_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic [ADDR_W-1:0] m0_addr_i = '0, m1_addr_i = '0;
    logic              m0_gnt_o, m1_gnt_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic              m0_rvalid_o, m1_rvalid_o, m0_rerr_o, m1_rerr_o;
    logic              rom_request_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic              rom_dataOk_i;

    rom_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m0_req_i      (m0_req_i),
        .m0_addr_i     (m0_addr_i),
        .m0_gnt_o      (m0_gnt_o),
        .m0_rdata_o    (m0_rdata_o),
        .m0_rvalid_o   (m0_rvalid_o),
        .m0_rerr_o     (m0_rerr_o),
        .m1_req_i      (m1_req_i),
        .m1_addr_i     (m1_addr_i),
        .m1_gnt_o      (m1_gnt_o),
        .m1_rdata_o    (m1_rdata_o),
        .m1_rvalid_o   (m1_rvalid_o),
        .m1_rerr_o     (m1_rerr_o),
        .rom_request_o (rom_request_o),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .rom_dataOk_i  (rom_dataOk_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ROM model: answers one cycle after it samples a request.
    logic              rom_en   = 1'b1;
    logic              force_ok = 1'b0;
    logic              model_ok = 1'b0;
    logic [DATA_W-1:0] model_data = '0;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ~a;
    endfunction

    always @(posedge clk) begin
        model_ok   <= rom_en && rom_request_o;
        model_data <= rom_fn(rom_addr_o);
    end
    assign rom_dataOk_i = model_ok | force_ok;
    assign rom_data_i   = force_ok ? 32'h1234_5678 : model_data;

    // Event logs and per-cycle invariants.
    int          g_cyc[$];
    bit          g_port[$];
    int          r_cyc[$];
    bit          r_port[$];
    logic [31:0] r_data[$];
    bit          r_err[$];

    always begin
        @(negedge clk);
        #2;
        if (m0_gnt_o) begin g_cyc.push_back(cyc); g_port.push_back(1'b0); end
        if (m1_gnt_o) begin g_cyc.push_back(cyc); g_port.push_back(1'b1); end
        if (m0_rvalid_o) begin
            r_cyc.push_back(cyc); r_port.push_back(1'b0);
            r_data.push_back(m0_rdata_o); r_err.push_back(m0_rerr_o);
        end
        if (m1_rvalid_o) begin
            r_cyc.push_back(cyc); r_port.push_back(1'b1);
            r_data.push_back(m1_rdata_o); r_err.push_back(m1_rerr_o);
        end
        check("gnt_both", m0_gnt_o & m1_gnt_o, 0);
        check("gnt_with_resp", (m0_gnt_o | m1_gnt_o) & (m0_rvalid_o | m1_rvalid_o), 0);
        if (!m0_rvalid_o) check("m0_quiet", {m0_rerr_o, m0_rdata_o}, 0);
        if (!m1_rvalid_o) check("m1_quiet", {m1_rerr_o, m1_rdata_o}, 0);
    end

    task automatic clear_logs();
        g_cyc.delete(); g_port.delete();
        r_cyc.delete(); r_port.delete(); r_data.delete(); r_err.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic do_req(input bit p, input logic [31:0] a, output int gcyc, output int waited);
        int start;
        bit got;
        @(negedge clk);
        start = cyc; gcyc = -1; waited = -1; got = 1'b0;
        if (p) begin m1_req_i = 1'b1; m1_addr_i = a; end
        else   begin m0_req_i = 1'b1; m0_addr_i = a; end
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if (p ? m1_gnt_o : m0_gnt_o) begin
                got = 1'b1; gcyc = cyc; waited = cyc - start;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check(p ? "m1_gnt_wait" : "m0_gnt_wait", p ? m1_gnt_o : m0_gnt_o, 1);
        if (p) m1_req_i = 1'b0; else m0_req_i = 1'b0;
    endtask

    task automatic check_resp(input string tag, input int idx, input bit port, input int rc,
                              input logic [31:0] data, input bit err);
        if (r_cyc.size() > idx) begin
            check({tag, "_port"}, r_port[idx], port);
            check({tag, "_cyc"},  r_cyc[idx],  rc);
            check({tag, "_data"}, r_data[idx], data);
            check({tag, "_err"},  r_err[idx],  err);
        end else begin
            check({tag, "_missing"}, r_cyc.size(), idx + 1);
        end
    endtask

    int g, w, g0, g1, w0, w1;

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        // Reset state, with both requesters active.
        reset_n = 1'b0;
        m0_req_i = 1'b1; m0_addr_i = 32'h20;
        m1_req_i = 1'b1; m1_addr_i = 32'h40;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", {m1_gnt_o, m0_gnt_o}, 0);
        check("rst_rvalid", {m1_rvalid_o, m0_rvalid_o, m1_rerr_o, m0_rerr_o}, 0);
        check("rst_rdata", {m1_rdata_o, m0_rdata_o}, 0);
        check("rst_rom_req", rom_request_o, 0);
        check("rst_rom_addr", rom_addr_o, 0);
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();

        // Single fetch.
        do_req(1'b0, 32'h10, g, w);
        check("t1_wait", w, 0);
        @(negedge clk);
        check("t1_rom_req", rom_request_o, 1);
        check("t1_rom_addr", rom_addr_o, 32'h10);
        @(negedge clk);
        check("t1_rom_req_drop", rom_request_o, 0);
        check("t1_m0_rvalid", m0_rvalid_o, 1);
        check("t1_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        check("t1_m1_out", {m1_rvalid_o, m1_rerr_o, m1_rdata_o}, 0);
        repeat (3) @(negedge clk);
        check("t1_resp_cnt", r_cyc.size(), 1);
        check_resp("t1_resp", 0, 1'b0, g + 2, 32'hDEAD_BEEF, 1'b0);

        // Contention after reset.
        apply_reset();
        clear_logs();
        fork
            do_req(1'b0, 32'h20, g0, w0);
            do_req(1'b1, 32'h40, g1, w1);
        join
        repeat (6) @(negedge clk);
        check("t2_p0_first", w0, 0);
        check("t2_p1_gap", g1 - g0, 3);
        check_resp("t2_r0", 0, 1'b0, g0 + 2, 32'hFFFF_FFDF, 1'b0);
        check_resp("t2_r1", 1, 1'b1, g1 + 2, 32'hFFFF_FFBF, 1'b0);

        // Fairness with both requests held.
        apply_reset();
        clear_logs();
        @(negedge clk);
        m0_req_i = 1'b1; m0_addr_i = 32'h20;
        m1_req_i = 1'b1; m1_addr_i = 32'h40;
        #3;
        for (int i = 0; i < 40 && g_cyc.size() < 6; i++) begin
            @(negedge clk);
            #3;
        end
        @(posedge clk);
        #1;
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        repeat (6) @(negedge clk);
        check("t3_gnt_cnt", g_cyc.size(), 6);
        for (int i = 0; i < 6 && i < g_cyc.size(); i++) begin
            check("t3_gnt_port", g_port[i], i % 2);
            if (i > 0) check("t3_gnt_gap", g_cyc[i] - g_cyc[i-1], 3);
            check_resp("t3_resp", i, bit'(i % 2), g_cyc[i] + 2,
                       (i % 2) ? 32'hFFFF_FFBF : 32'hFFFF_FFDF, 1'b0);
        end

        // Timeout, then a normal access.
        rom_en = 1'b0;
        clear_logs();
        do_req(1'b1, 32'h80, g, w);
        repeat (20) @(negedge clk);
        check("t4_resp_cnt", r_cyc.size(), 1);
        check_resp("t4_to", 0, 1'b1, g + 2 + TIMEOUT - 1, 32'h0, 1'b1);
        rom_en = 1'b1;
        clear_logs();
        do_req(1'b0, 32'h40, g, w);
        check("t4_idle_again", w, 0);
        repeat (4) @(negedge clk);
        check_resp("t4_after", 0, 1'b0, g + 2, 32'hFFFF_FFBF, 1'b0);

        // Reset in WAIT, then contention.
        rom_en = 1'b0;
        clear_logs();
        do_req(1'b0, 32'h20, g, w);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_rom_req", rom_request_o, 0);
        check("t5_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
        rom_en = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_resp", r_cyc.size(), 0);
        fork
            do_req(1'b1, 32'h40, g1, w1);
            do_req(1'b0, 32'h20, g0, w0);
        join
        check("t5_p0_first", w0, 0);
        check("t5_p1_gap", g1 - g0, 3);

        // Reset in ISSUE drops rom_request_o at once.
        repeat (4) @(negedge clk);
        clear_logs();
        do_req(1'b0, 32'h10, g, w);
        @(negedge clk);
        check("t5b_rom_req_pre", rom_request_o, 1);
        reset_n = 1'b0;
        #1;
        check("t5b_rom_req", rom_request_o, 0);
        check("t5b_rom_addr", rom_addr_o, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t5b_no_resp", r_cyc.size(), 0);

        // Stray dataOk while idle.
        clear_logs();
        @(negedge clk);
        force_ok = 1'b1;
        #1;
        check("t6_stray_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
        @(negedge clk);
        force_ok = 1'b0;
        do_req(1'b1, 32'h40, g, w);
        check("t6_still_idle", w, 0);
        repeat (4) @(negedge clk);
        check("t6_resp_cnt", r_cyc.size(), 1);
        check_resp("t6_resp", 0, 1'b1, g + 2, 32'hFFFF_FFBF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
